seg_scan_decoder: RTL and testbench

- Receive end of the 4-digit multiplexed 7-segment interface (an/seg) driven by the display block.
- Samples the scanned anode/segment lines and decodes each glyph back to a hex nibble.
- Reassembles the 16-bit displayed value and reports it with a per-frame valid pulse.
- Used as a self-check/monitor in calculator builds and as the reference checker in display benches.

---
 rtl/seg_scan_decoder_pkg.sv | 37 +++
 rtl/seg_scan_decoder_if.sv | 25 ++
 rtl/seg_scan_decoder_glyph_decode.sv | 35 +++
 rtl/seg_scan_decoder.sv | 114 +++++++++++
 tb/tb_seg_scan_decoder.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Package for the scanned 7-segment receive path.
// Holds the active-low glyph constants shared with the display encoder,
// the digit count, the dwell FSM encoding and a one-hot index helper.
package seg_scan_decoder_pkg;

  localparam int DIGITS = 4;

  // Active-low segment patterns, seg[0]=a .. seg[6]=g.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic {WAIT = 1'b0, HOLD = 1'b1} dwell_state_e;

  // Index of the single set bit; only meaningful when sel is one-hot.
  function automatic logic [1:0] onehot_idx(input logic [DIGITS-1:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < DIGITS; i++)
      if (sel[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Scanned display bus plus the decoded-result signals.
//   master: drives an/seg (display side / bench), observes results.
//   slave : the decoder; samples an/seg, drives results.
interface seg_scan_decoder_if;
  import seg_scan_decoder_pkg::*;

  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic [4*DIGITS-1:0] value;
  logic                value_valid;
  logic                value_changed;
  logic [DIGITS-1:0]   digit_mask;
  logic                err_glyph;
  logic                err_anode;

  modport master (
    output an, seg,
    input  value, value_valid, value_changed, digit_mask, err_glyph, err_anode
  );

  modport slave (
    input  an, seg,
    output value, value_valid, value_changed, digit_mask, err_glyph, err_anode
  );
endinterface

// File: rtl/seg_scan_decoder_glyph_decode.sv
// seg_glyph_decode: combinational active-low 7-seg pattern -> hex nibble.
//   seg_i   : 7-bit active-low pattern
//   nib_o   : decoded nibble (0 when illegal)
//   legal_o : pattern is one of the 16 hex glyphs
module seg_glyph_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nib_o,
  output logic       legal_o
);
  always_comb begin
    nib_o   = 4'h0;
    legal_o = 1'b1;
    case (seg_i)
      SEG_0: nib_o = 4'h0;
      SEG_1: nib_o = 4'h1;
      SEG_2: nib_o = 4'h2;
      SEG_3: nib_o = 4'h3;
      SEG_4: nib_o = 4'h4;
      SEG_5: nib_o = 4'h5;
      SEG_6: nib_o = 4'h6;
      SEG_7: nib_o = 4'h7;
      SEG_8: nib_o = 4'h8;
      SEG_9: nib_o = 4'h9;
      SEG_A: nib_o = 4'hA;
      SEG_B: nib_o = 4'hB;
      SEG_C: nib_o = 4'hC;
      SEG_D: nib_o = 4'hD;
      SEG_E: nib_o = 4'hE;
      SEG_F: nib_o = 4'hF;
      default: legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: monitors a 4-digit multiplexed 7-seg scan and
// reassembles the displayed 16-bit value.
//   clk, reset : clock, synchronous active-high reset
//   bus.an/seg : scanned anodes / segments, both active-low (inputs)
//   bus.value  : last completed frame; value_valid / value_changed pulses
//   bus.digit_mask : digits captured in the frame being assembled
//   bus.err_glyph / err_anode : sticky error flags
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                reset,
  seg_scan_decoder_if.slave   bus
);
  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  logic [DIGITS+6:0]   prev_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  dwell_state_e        state_q, state_d;
  logic [4*DIGITS-1:0] frame_q, frame_d, value_q;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                valid_q, changed_q, err_glyph_q, err_anode_q;

  logic [DIGITS+6:0] sample;
  logic              same, settled, capture, complete;
  logic [DIGITS-1:0] sel;
  logic              blank, one_hot, multi;
  logic [3:0]        nib;
  logic              legal;
  logic [1:0]        idx;

  seg_glyph_decode u_dec (.seg_i(seg_q), .nib_o(nib), .legal_o(legal));

  assign sample   = {an_q, seg_q};
  assign same     = (sample == prev_q);
  assign settled  = same && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
  assign sel      = ~an_q;
  assign blank    = (sel == '0);
  assign one_hot  = $onehot(sel);
  assign multi    = !blank && !one_hot;
  assign idx      = onehot_idx(sel);
  assign complete = (mask_q == '1);

  // Counter saturates so a long dwell can never re-hit the settle point.
  always_comb begin
    cnt_d = '0;
    if (same)
      cnt_d = (cnt_q == CNT_W'(SETTLE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      WAIT: if (settled) begin
        state_d = HOLD;
        capture = 1'b1;
      end
      HOLD: if (!same) state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  // A completing frame clears the mask first so a coincident capture
  // starts the next frame.
  always_comb begin
    mask_d  = complete ? '0 : mask_q;
    frame_d = frame_q;
    if (capture && one_hot && legal) begin
      mask_d[idx]                   = 1'b1;
      frame_d[{idx, 2'b00} +: 4]    = nib;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q        <= '0;
      seg_q       <= '0;
      prev_q      <= '0;
      cnt_q       <= '0;
      state_q     <= WAIT;
      frame_q     <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
      err_glyph_q <= 1'b0;
      err_anode_q <= 1'b0;
    end else begin
      an_q      <= bus.an;
      seg_q     <= bus.seg;
      prev_q    <= sample;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      frame_q   <= frame_d;
      mask_q    <= mask_d;
      valid_q   <= complete;
      changed_q <= complete && (frame_q != value_q);
      if (complete) value_q <= frame_q;
      if (capture && one_hot && !legal) err_glyph_q <= 1'b1;
      if (capture && multi)             err_anode_q <= 1'b1;
    end
  end

  assign bus.value         = value_q;
  assign bus.value_valid   = valid_q;
  assign bus.value_changed = changed_q;
  assign bus.digit_mask    = mask_q;
  assign bus.err_glyph     = err_glyph_q;
  assign bus.err_anode     = err_anode_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (SETTLE_CYCLES=4).
module tb_seg_scan_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   vcnt = 0;
  int   ccnt = 0;

  seg_scan_decoder_if bus();

  seg_scan_decoder #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.value_valid)   vcnt++;
    if (bus.value_changed) ccnt++;
  end

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    bus.an  = a;
    bus.seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [15:0] v, input int n);
    logic [3:0] nib;
    for (int d = 0; d < 4; d++) begin
      logic [3:0] a;
      a = 4'hF;
      a[d] = 1'b0;
      nib = v[4*d +: 4];
      dwell(a, glyph[nib], n);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.an = 4'hF; bus.seg = 7'h7F;
    do_reset();
    chk("reset_value", 32'(bus.value), 32'h0);
    chk("reset_valid", 32'(bus.value_valid), 32'h0);
    chk("reset_mask",  32'(bus.digit_mask), 32'h0);
    chk("reset_errs",  32'({bus.err_glyph, bus.err_anode}), 32'h0);
  endtask

  task automatic test_scan();
    int v0, c0;
    v0 = vcnt; c0 = ccnt;
    scan(16'h0135, 8);
    chk("scan1_value",   32'(bus.value), 32'h0135);
    chk("scan1_valid",   32'(vcnt - v0), 32'd1);
    chk("scan1_changed", 32'(ccnt - c0), 32'd1);
    chk("scan1_mask",    32'(bus.digit_mask), 32'h0);
    v0 = vcnt; c0 = ccnt;
    scan(16'h0135, 8);
    chk("scan2_valid",   32'(vcnt - v0), 32'd1);
    chk("scan2_changed", 32'(ccnt - c0), 32'd0);
    v0 = vcnt; c0 = ccnt;
    scan(16'hABCD, 8);
    chk("scan3_value",   32'(bus.value), 32'hABCD);
    chk("scan3_changed", 32'(ccnt - c0), 32'd1);
  endtask

  task automatic test_short_and_glitch();
    int v0;
    v0 = vcnt;
    scan(16'h1111, 3);
    dwell(4'hF, 7'h7F, 8);
    chk("short_mask",  32'(bus.digit_mask), 32'h0);
    chk("short_valid", 32'(vcnt - v0), 32'd0);
    // digit 0 = 4 with a one-cycle glitch, then a too-short re-dwell
    dwell(4'hE, 7'h19, 6);
    dwell(4'hE, 7'h79, 1);
    dwell(4'hE, 7'h19, 1);
    chk("glitch_mask", 32'(bus.digit_mask), 32'h1);
    dwell(4'hD, 7'h10, 8);
    dwell(4'hB, 7'h00, 8);
    dwell(4'h7, 7'h02, 8);
    chk("glitch_value", 32'(bus.value), 32'h6894);
    chk("glitch_valid", 32'(vcnt - v0), 32'd1);
  endtask

  task automatic test_glyph_err();
    int v0;
    chk("glyph_err_pre", 32'(bus.err_glyph), 32'h0);
    dwell(4'hE, 7'h7F, 8);
    chk("glyph_err_set", 32'(bus.err_glyph), 32'h1);
    chk("glyph_err_mask", 32'(bus.digit_mask), 32'h0);
    v0 = vcnt;
    scan(16'h1234, 8);
    chk("glyph_err_value", 32'(bus.value), 32'h1234);
    chk("glyph_err_valid", 32'(vcnt - v0), 32'd1);
    chk("glyph_err_sticky", 32'(bus.err_glyph), 32'h1);
  endtask

  task automatic test_anode_err();
    int v0;
    v0 = vcnt;
    chk("anode_err_pre", 32'(bus.err_anode), 32'h0);
    dwell(4'b1100, 7'h00, 8);
    chk("anode_err_set", 32'(bus.err_anode), 32'h1);
    chk("anode_err_mask", 32'(bus.digit_mask), 32'h0);
    dwell(4'b1111, 7'h00, 8);
    chk("blank_mask", 32'(bus.digit_mask), 32'h0);
    chk("blank_valid", 32'(vcnt - v0), 32'd0);
    chk("blank_anode_sticky", 32'(bus.err_anode), 32'h1);
  endtask

  task automatic test_reset_midframe();
    int v0, c0;
    dwell(4'hE, 7'h40, 8);
    dwell(4'hD, 7'h40, 8);
    chk("mid_mask", 32'(bus.digit_mask), 32'h3);
    do_reset();
    chk("mid_rst_value", 32'(bus.value), 32'h0);
    chk("mid_rst_mask",  32'(bus.digit_mask), 32'h0);
    chk("mid_rst_errs",  32'({bus.err_glyph, bus.err_anode}), 32'h0);
    v0 = vcnt; c0 = ccnt;
    dwell(4'hE, 7'h24, 8);
    dwell(4'hD, 7'h19, 8);
    dwell(4'hB, 7'h40, 8);
    chk("mid_3dwell_valid", 32'(vcnt - v0), 32'd0);
    chk("mid_3dwell_mask",  32'(bus.digit_mask), 32'h7);
    dwell(4'h7, 7'h40, 8);
    chk("mid_value",   32'(bus.value), 32'h0042);
    chk("mid_valid",   32'(vcnt - v0), 32'd1);
    chk("mid_changed", 32'(ccnt - c0), 32'd1);
  endtask

  initial begin
    bus.an = 4'hF;
    bus.seg = 7'h7F;
    test_reset();
    test_scan();
    test_short_and_glitch();
    test_glyph_err();
    test_anode_err();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
